mask_thresh_pipe: RTL and testbench

MASK_THRESH_PIPE -- requirements
Module: mask_thresh_pipe

---
 rtl/mask_thresh_pipe.sv | 151 +++++++++++++++
 tb/tb_mask_thresh_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mask_thresh_pipe.sv
// Two-stage pixel mask pipeline: channel select, window / RGB-box thresholding,
// frame-synchronous bound reload and a saturating per-frame masked-pixel counter.
module mask_thresh_pipe #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 20
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               valid_in,
  input  logic               frame_start_in,
  input  logic [WIDTH-1:0]   r_in,
  input  logic [WIDTH-1:0]   g_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [WIDTH-1:0]   y_in,
  input  logic [WIDTH-1:0]   cr_in,
  input  logic [WIDTH-1:0]   cb_in,
  input  logic [2:0]         sel_in,
  input  logic [1:0]         mode_in,
  input  logic               cfg_we_in,
  input  logic [2:0]         cfg_addr_in,
  input  logic [WIDTH-1:0]   cfg_data_in,
  output logic               valid_out,
  output logic               frame_start_out,
  output logic               mask_out,
  output logic [WIDTH-1:0]   channel_out,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid_out
);

  localparam logic [WIDTH-1:0]   W_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   W_ONES  = {WIDTH{1'b1}};
  localparam logic [COUNT_W-1:0] C_ZERO  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] C_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] C_MAX   = {COUNT_W{1'b1}};

  // Bound index map: 0/1 sel window, 2/3 red, 4/5 green, 6/7 blue (even = lo, odd = hi).
  logic [WIDTH-1:0] sh_q  [8];
  logic [WIDTH-1:0] sh_d  [8];
  logic [WIDTH-1:0] act_q [8];
  logic [WIDTH-1:0] act_d [8];
  logic             load_s;
  logic [WIDTH-1:0] ch_s;

  logic             v1_q, v1_d, fs1_q, fs1_d, win1_q, win1_d, box1_q, box1_d;
  logic [1:0]       mode1_q, mode1_d;
  logic [WIDTH-1:0] ch1_q, ch1_d;

  logic             v2_q, v2_d, fs2_q, fs2_d, mask2_q, mask2_d;
  logic [WIDTH-1:0] ch2_q, ch2_d;

  logic [COUNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
  logic               cntv_q, cntv_d;

  // Shadow writes, frame-start reload, channel mux and stage-1 comparisons.
  always_comb begin
    load_s = valid_in & frame_start_in;
    for (int i = 0; i < 8; i++) begin
      sh_d[i]  = (cfg_we_in && (cfg_addr_in == 3'(i))) ? cfg_data_in : sh_q[i];
      act_d[i] = load_s ? sh_q[i] : act_q[i];
    end
    case (sel_in)
      3'b000:  ch_s = g_in;
      3'b001:  ch_s = r_in;
      3'b010:  ch_s = b_in;
      3'b100:  ch_s = y_in;
      3'b101:  ch_s = cr_in;
      3'b110:  ch_s = cb_in;
      default: ch_s = W_ZERO;
    endcase
    v1_d    = valid_in;
    fs1_d   = load_s;
    ch1_d   = ch_s;
    mode1_d = mode_in;
    // An inverted window (lo > hi) can never satisfy both compares, so it yields 0.
    win1_d  = (act_d[0] <= ch_s) && (ch_s <= act_d[1]);
    box1_d  = (act_d[2] <= r_in) && (r_in <= act_d[3]) &&
              (act_d[4] <= g_in) && (g_in <= act_d[5]) &&
              (act_d[6] <= b_in) && (b_in <= act_d[7]);
  end

  // Stage-2 mask combine and frame counter bookkeeping.
  always_comb begin
    case (mode1_q)
      2'b00:   mask2_d = v1_q & win1_q;
      2'b01:   mask2_d = v1_q & box1_q;
      2'b10:   mask2_d = v1_q & ~win1_q;
      default: mask2_d = 1'b0;
    endcase
    v2_d   = v1_q;
    fs2_d  = v1_q & fs1_q;
    ch2_d  = v1_q ? ch1_q : ch2_q;
    cntv_d = fs2_d;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (fs2_d) begin
      cnt_d = acc_q;
      acc_d = mask2_d ? C_ONE : C_ZERO;
    end else if (mask2_d && (acc_q != C_MAX)) begin
      acc_d = acc_q + C_ONE;
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 8; i++) begin
        sh_q[i]  <= (i % 2 == 1) ? W_ONES : W_ZERO;
        act_q[i] <= (i % 2 == 1) ? W_ONES : W_ZERO;
      end
      v1_q    <= 1'b0;
      fs1_q   <= 1'b0;
      win1_q  <= 1'b0;
      box1_q  <= 1'b0;
      mode1_q <= 2'b00;
      ch1_q   <= W_ZERO;
      v2_q    <= 1'b0;
      fs2_q   <= 1'b0;
      mask2_q <= 1'b0;
      ch2_q   <= W_ZERO;
      acc_q   <= C_ZERO;
      cnt_q   <= C_ZERO;
      cntv_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      act_q   <= act_d;
      v1_q    <= v1_d;
      fs1_q   <= fs1_d;
      win1_q  <= win1_d;
      box1_q  <= box1_d;
      mode1_q <= mode1_d;
      ch1_q   <= ch1_d;
      v2_q    <= v2_d;
      fs2_q   <= fs2_d;
      mask2_q <= mask2_d;
      ch2_q   <= ch2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cntv_q  <= cntv_d;
    end
  end

  assign valid_out       = v2_q;
  assign frame_start_out = fs2_q;
  assign mask_out        = mask2_q;
  assign channel_out     = ch2_q;
  assign count_out       = cnt_q;
  assign count_valid_out = cntv_q;

endmodule

// File: tb/tb_mask_thresh_pipe.sv
// Directed bench for mask_thresh_pipe: a default instance plus a COUNT_W=3 instance
// sharing the same stimulus to observe counter saturation.
module tb_mask_thresh_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in, frame_start_in, cfg_we_in;
  logic [3:0] r_in, g_in, b_in, y_in, cr_in, cb_in, cfg_data_in;
  logic [2:0] sel_in, cfg_addr_in;
  logic [1:0] mode_in;

  logic        v_o, fs_o, m_o, cv_o;
  logic [3:0]  ch_o;
  logic [19:0] cnt_o;
  logic        v3_o, fs3_o, m3_o, cv3_o;
  logic [3:0]  ch3_o;
  logic [2:0]  cnt3_o;

  int errors = 0;
  int checks = 0;

  logic       p_v, p_fs, p_m;
  logic [3:0] p_ch, exp_ch;
  int         p_cnt, p_cnt3;

  always #5 clk = ~clk;

  mask_thresh_pipe #(.WIDTH(4), .COUNT_W(20)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .frame_start_in(frame_start_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .y_in(y_in), .cr_in(cr_in), .cb_in(cb_in),
    .sel_in(sel_in), .mode_in(mode_in), .cfg_we_in(cfg_we_in), .cfg_addr_in(cfg_addr_in),
    .cfg_data_in(cfg_data_in), .valid_out(v_o), .frame_start_out(fs_o), .mask_out(m_o),
    .channel_out(ch_o), .count_out(cnt_o), .count_valid_out(cv_o));

  mask_thresh_pipe #(.WIDTH(4), .COUNT_W(3)) dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .frame_start_in(frame_start_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .y_in(y_in), .cr_in(cr_in), .cb_in(cb_in),
    .sel_in(sel_in), .mode_in(mode_in), .cfg_we_in(cfg_we_in), .cfg_addr_in(cfg_addr_in),
    .cfg_data_in(cfg_data_in), .valid_out(v3_o), .frame_start_out(fs3_o), .mask_out(m3_o),
    .channel_out(ch3_o), .count_out(cnt3_o), .count_valid_out(cv3_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    chk("rst valid_out", {31'd0, v_o}, 32'd0);
    chk("rst mask_out", {31'd0, m_o}, 32'd0);
    chk("rst frame_start_out", {31'd0, fs_o}, 32'd0);
    chk("rst channel_out", {28'd0, ch_o}, 32'd0);
    chk("rst count_out", {12'd0, cnt_o}, 32'd0);
    chk("rst count_valid_out", {31'd0, cv_o}, 32'd0);
    chk("rst count3_out", {29'd0, cnt3_o}, 32'd0);
    chk("rst count3_valid", {31'd0, cv3_o}, 32'd0);
  endtask

  task automatic check_out();
    if (p_v) exp_ch = p_ch;
    chk("valid_out", {31'd0, v_o}, {31'd0, p_v});
    chk("frame_start_out", {31'd0, fs_o}, {31'd0, p_v & p_fs});
    chk("mask_out", {31'd0, m_o}, {31'd0, p_v & p_m});
    chk("channel_out", {28'd0, ch_o}, {28'd0, exp_ch});
    chk("count_valid_out", {31'd0, cv_o}, {31'd0, p_v & p_fs});
    chk("count3_valid_out", {31'd0, cv3_o}, {31'd0, p_v & p_fs});
    if (p_v && p_fs) begin
      chk("count_out", {12'd0, cnt_o}, 32'(p_cnt));
      chk("count3_out", {29'd0, cnt3_o}, 32'(p_cnt3));
    end
  endtask

  // Drives one cycle of pixel input, then checks the pixel issued on the previous call.
  task automatic tick(input logic v, input logic fs, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic em, input logic [3:0] ech,
                      input int ecnt, input int ecnt3);
    valid_in = v; frame_start_in = fs; r_in = r; g_in = g; b_in = b;
    @(posedge clk); #1;
    valid_in = 1'b0; frame_start_in = 1'b0; cfg_we_in = 1'b0;
    check_out();
    p_v = v; p_fs = fs; p_m = em; p_ch = ech; p_cnt = ecnt; p_cnt3 = ecnt3;
  endtask

  task automatic px(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                    input logic em, input logic [3:0] ech);
    tick(1'b1, 1'b0, r, g, b, em, ech, 0, 0);
  endtask

  task automatic fsx(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                     input logic em, input logic [3:0] ech, input int ecnt, input int ecnt3);
    tick(1'b1, 1'b1, r, g, b, em, ech, ecnt, ecnt3);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 0, 0);
  endtask

  task automatic cfg(input logic [2:0] addr, input logic [3:0] data);
    cfg_we_in = 1'b1; cfg_addr_in = addr; cfg_data_in = data;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; frame_start_in = 1'b0; cfg_we_in = 1'b0;
    cfg_addr_in = 3'd0; cfg_data_in = 4'd0;
    r_in = 4'd0; g_in = 4'd0; b_in = 4'd0; y_in = 4'd9; cr_in = 4'd3; cb_in = 4'd14;
    sel_in = 3'b001; mode_in = 2'b00;
    p_v = 1'b0; p_fs = 1'b0; p_m = 1'b0; p_ch = 4'd0; exp_ch = 4'd0; p_cnt = 0; p_cnt3 = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    @(negedge clk) rst_n = 1'b1;

    // Reset bounds, window on red; first frame start reports zero.
    fsx(4'd5, 4'd0, 4'd0, 1'b1, 4'd5, 0, 0);
    cfg(3'd0, 4'd8);  px(4'd10, 4'd0, 4'd0, 1'b1, 4'd10);
    cfg(3'd1, 4'd12); px(4'd10, 4'd0, 4'd0, 1'b1, 4'd10);
    px(4'd7, 4'd0, 4'd0, 1'b1, 4'd7);
    fsx(4'd7, 4'd0, 4'd0, 1'b0, 4'd7, 4, 4);
    px(4'd8, 4'd0, 4'd0, 1'b1, 4'd8);
    px(4'd12, 4'd0, 4'd0, 1'b1, 4'd12);
    px(4'd13, 4'd0, 4'd0, 1'b0, 4'd13);
    tick(1'b0, 1'b0, 4'd9, 4'd0, 4'd0, 1'b0, 4'd0, 0, 0);

    // sel_hi written in the frame-start cycle only takes effect one frame later.
    cfg(3'd1, 4'd9); fsx(4'd10, 4'd0, 4'd0, 1'b1, 4'd10, 2, 2);
    px(4'd10, 4'd0, 4'd0, 1'b1, 4'd10);
    fsx(4'd10, 4'd0, 4'd0, 1'b0, 4'd10, 2, 2);
    px(4'd9, 4'd0, 4'd0, 1'b1, 4'd9);

    // RGB box r 12..15, g 0..1, b 0..1; sel window becomes 13..9 (empty).
    cfg(3'd0, 4'd13); idle();
    cfg(3'd2, 4'd12); idle();
    cfg(3'd5, 4'd1);  idle();
    cfg(3'd7, 4'd1);  idle();
    mode_in = 2'b01;
    fsx(4'd13, 4'd0, 4'd1, 1'b1, 4'd13, 1, 1);
    px(4'd13, 4'd2, 4'd0, 1'b0, 4'd13);
    px(4'd11, 4'd0, 4'd0, 1'b0, 4'd11);
    px(4'd12, 4'd1, 4'd1, 1'b1, 4'd12);
    px(4'd15, 4'd0, 4'd0, 1'b1, 4'd15);
    mode_in = 2'b10; px(4'd5, 4'd0, 4'd0, 1'b1, 4'd5);
    mode_in = 2'b11; px(4'd13, 4'd0, 4'd1, 1'b0, 4'd13);
    mode_in = 2'b10; sel_in = 3'b011; px(4'd5, 4'd0, 4'd0, 1'b1, 4'd0);
    sel_in = 3'b110; px(4'd5, 4'd0, 4'd0, 1'b1, 4'd14);
    mode_in = 2'b11; sel_in = 3'b001; px(4'd13, 4'd0, 4'd1, 1'b0, 4'd13);

    // Ten pixels, six masked; then a frame of ten masked pixels to saturate COUNT_W=3.
    mode_in = 2'b01;
    fsx(4'd12, 4'd0, 4'd0, 1'b1, 4'd12, 6, 6);
    for (int i = 0; i < 9; i++) px(4'd12, 4'd0, 4'd0, 1'b1, 4'd12);
    fsx(4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 10, 7);
    mode_in = 2'b10; sel_in = 3'b100; px(4'd0, 4'd0, 4'd0, 1'b1, 4'd9);
    sel_in = 3'b101; px(4'd0, 4'd0, 4'd0, 1'b1, 4'd3);
    mode_in = 2'b01; sel_in = 3'b001; px(4'd12, 4'd0, 4'd0, 1'b1, 4'd12);
    px(4'd12, 4'd0, 4'd0, 1'b1, 4'd12);

    // Reset mid-frame with pixels in flight: partial count and bounds are discarded.
    #3 rst_n = 1'b0;
    #1 check_reset_state();
    p_v = 1'b0; exp_ch = 4'd0;
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    @(negedge clk) rst_n = 1'b1;
    mode_in = 2'b00;
    fsx(4'd4, 4'd0, 4'd0, 1'b1, 4'd4, 0, 0);
    px(4'd6, 4'd0, 4'd0, 1'b1, 4'd6);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
